// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle RV32I-style base ops plus iterative
// M-extension multiply (shift-add) and divide (restoring division).
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   ALU_A, ALU_B      operands, captured on the accept edge
//   ALU_FUN           op select; bit4=0 base op, bit4=1 M-extension op
//   OP_VALID/OP_READY request handshake (ready only when idle)
//   RES_VALID/RES_READY result handshake; ALU_RESULT held until taken
//   ALU_RESULT        registered result, zero while idle or busy
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] ALU_A,
    input  logic [WIDTH-1:0] ALU_B,
    input  logic [4:0]       ALU_FUN,
    input  logic             OP_VALID,
    output logic             OP_READY,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] ALU_RESULT
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [1:0]         fun_q, fun_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   base_res;

    logic               a_signed, b_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, div_ovf;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_prod;
    logic [WIDTH-1:0]   mul_res;

    logic [WIDTH:0]     div_shift, div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem, div_quo, div_sel, div_res;
    logic [2*WIDTH-1:0] div_next;

    assign OP_READY   = (state_q == IDLE);
    assign RES_VALID  = (state_q == DONE);
    assign ALU_RESULT = res_q;

    // Base (single-cycle) operations
    always_comb begin
        shamt    = ALU_B[SHW-1:0];
        base_res = '0;
        case (ALU_FUN[3:0])
            4'b0000: base_res = ALU_A + ALU_B;
            4'b1000: base_res = ALU_A - ALU_B;
            4'b0110: base_res = ALU_A | ALU_B;
            4'b0111: base_res = ALU_A & ALU_B;
            4'b0100: base_res = ALU_A ^ ALU_B;
            4'b0101: base_res = ALU_A >> shamt;
            4'b0001: base_res = ALU_A << shamt;
            4'b1101: base_res = WIDTH'($signed(ALU_A) >>> shamt);
            4'b0010: base_res = {{(WIDTH-1){1'b0}},
                                 $signed(ALU_A) < $signed(ALU_B)};
            4'b0011: base_res = {{(WIDTH-1){1'b0}}, ALU_A < ALU_B};
            4'b1001: base_res = ALU_A;
            default: base_res = '0;
        endcase
    end

    // Operand magnitudes and sign handling for M ops.
    // MUL (000) is treated as signed x signed; its low half is the
    // same either way.
    always_comb begin
        if (ALU_FUN[2]) begin
            a_signed = ~ALU_FUN[0];
            b_signed = ~ALU_FUN[0];
        end else begin
            a_signed = (ALU_FUN[1:0] != 2'b11);
            b_signed = ~ALU_FUN[1];
        end
        a_neg    = a_signed & ALU_A[WIDTH-1];
        b_neg    = b_signed & ALU_B[WIDTH-1];
        a_mag    = a_neg ? -ALU_A : ALU_A;
        b_mag    = b_neg ? -ALU_B : ALU_B;
        div_zero = (ALU_B == '0);
        div_ovf  = ~ALU_FUN[0] & (ALU_A == MIN_NEG) & (&ALU_B);
    end

    // One shift-add step: acc = {partial product, remaining multiplier}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        mul_prod = neg_q ? -mul_next : mul_next;
        mul_res  = (fun_q == 2'b00) ? mul_prod[WIDTH-1:0]
                                    : mul_prod[2*WIDTH-1:WIDTH];
    end

    // One restoring step: acc = {partial remainder, dividend/quotient}
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_ge    = ~div_trial[WIDTH];
        div_rem   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {acc_q[WIDTH-2:0], div_ge};
        div_next  = {div_rem, div_quo};
        div_sel   = fun_q[1] ? div_rem : div_quo;
        div_res   = neg_q ? -div_sel : div_sel;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        fun_d   = fun_q;
        neg_d   = neg_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (OP_VALID) begin
                    if (!ALU_FUN[4]) begin
                        res_d   = base_res;
                        state_d = DONE;
                    end else begin
                        fun_d = ALU_FUN[1:0];
                        cnt_d = '0;
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        opb_d = b_mag;
                        if (!ALU_FUN[2]) begin
                            neg_d   = a_neg ^ b_neg;
                            state_d = MUL;
                        end else if (div_zero) begin
                            res_d   = ALU_FUN[1] ? ALU_A : '1;
                            state_d = DONE;
                        end else if (div_ovf) begin
                            res_d   = ALU_FUN[1] ? '0 : ALU_A;
                            state_d = DONE;
                        end else begin
                            neg_d   = ALU_FUN[1] ? a_neg : (a_neg ^ b_neg);
                            state_d = DIV;
                        end
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = mul_res;
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = div_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (RES_READY) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            fun_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            fun_q   <= fun_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu: directed and random ops at WIDTH=32 and
// WIDTH=8, checked against an arithmetic reference model.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [4:0]  fun;
    logic        op_valid, res_ready;
    int          cur_w = 32;

    logic        opr32, rv32, opr8, rv8;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic        opr, rv;
    logic [63:0] res;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign opr = (cur_w == 8) ? opr8 : opr32;
    assign rv  = (cur_w == 8) ? rv8 : rv32;
    assign res = (cur_w == 8) ? {56'b0, res8} : {32'b0, res32};

    multicycle_alu #(.WIDTH(32)) dut32 (
        .CLK(clk), .RST(rst), .ALU_A(a), .ALU_B(b), .ALU_FUN(fun),
        .OP_VALID(op_valid && cur_w == 32), .OP_READY(opr32),
        .RES_VALID(rv32), .RES_READY(res_ready), .ALU_RESULT(res32)
    );

    multicycle_alu #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .ALU_A(a[7:0]), .ALU_B(b[7:0]),
        .ALU_FUN(fun), .OP_VALID(op_valid && cur_w == 8),
        .OP_READY(opr8), .RES_VALID(rv8), .RES_READY(res_ready),
        .ALU_RESULT(res8)
    );

    function automatic logic [63:0] model(input int w, input logic [4:0] f,
                                          input logic [31:0] ai,
                                          input logic [31:0] bi);
        logic [63:0] mask, ua, ub, r, mn;
        longint sa, sb, p;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        mn   = 64'd1 << (w - 1);
        ua   = {32'b0, ai} & mask;
        ub   = {32'b0, bi} & mask;
        sa   = (ua >= mn) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
        sb   = (ub >= mn) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
        sh   = int'(ub % 64'(w));
        r    = '0;
        if (!f[4]) begin
            case (f[3:0])
                4'b0000: r = ua + ub;
                4'b1000: r = ua - ub;
                4'b0110: r = ua | ub;
                4'b0111: r = ua & ub;
                4'b0100: r = ua ^ ub;
                4'b0101: r = ua >> sh;
                4'b0001: r = ua << sh;
                4'b1101: r = 64'(sa >>> sh);
                4'b0010: r = (sa < sb) ? 64'd1 : 64'd0;
                4'b0011: r = (ua < ub) ? 64'd1 : 64'd0;
                4'b1001: r = ua;
                default: r = '0;
            endcase
        end else begin
            case (f[2:0])
                3'b000: r = ua * ub;
                3'b001: begin p = sa * sb; r = 64'(p >>> w); end
                3'b010: begin p = sa * longint'(ub); r = 64'(p >>> w); end
                3'b011: r = (ua * ub) >> w;
                3'b100: begin
                    if (ub == 0) r = mask;
                    else if (ua == mn && ub == mask) r = ua;
                    else r = 64'(sa / sb);
                end
                3'b101: r = (ub == 0) ? mask : ua / ub;
                3'b110: begin
                    if (ub == 0) r = ua;
                    else if (ua == mn && ub == mask) r = 0;
                    else r = 64'(sa % sb);
                end
                default: r = (ub == 0) ? ua : ua % ub;
            endcase
        end
        return r & mask;
    endfunction

    function automatic int lat_model(input int w, input logic [4:0] f,
                                     input logic [31:0] ai,
                                     input logic [31:0] bi);
        logic [63:0] mask, ua, ub;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'b0, ai} & mask;
        ub   = {32'b0, bi} & mask;
        if (!f[4]) return 1;
        if (!f[2]) return w + 1;
        if (ub == 0) return 1;
        if (!f[0] && ua == (64'd1 << (w - 1)) && ub == mask) return 1;
        return w + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [4:0] f, input logic [31:0] av,
                            input logic [31:0] bv);
        fun       = f;
        a         = av;
        b         = bv;
        op_valid  = 1'b1;
        res_ready = 1'b0;
        tick();
        op_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        fun      = 5'($urandom);
    endtask

    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [63:0] exp_res);
        int n;
        n = 1;
        if (!rv) check({tag, "_busy0"}, res, 64'd0);
        while (!rv && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, res, exp_res);
    endtask

    task automatic pop(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_idle"}, {62'b0, opr, rv}, 64'b10);
        check({tag, "_zero"}, res, 64'd0);
    endtask

    task automatic run_exp(input string tag, input logic [4:0] f,
                           input logic [31:0] av, input logic [31:0] bv,
                           input int lat, input logic [63:0] exp_res);
        start_op(f, av, bv);
        wait_result(tag, lat, exp_res);
        pop(tag);
    endtask

    task automatic run_model(input string tag, input logic [4:0] f,
                             input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] e;
        int l;
        e = model(cur_w, f, av, bv);
        l = lat_model(cur_w, f, av, bv);
        run_exp(tag, f, av, bv, l, e);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] one;
        one = 32'd1;
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return '1;
            2: return one << (w - 1);
            3: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic random_ops(input int count);
        logic [4:0] codes [19];
        logic [4:0] f;
        logic [31:0] av, bv;
        codes = '{5'h00, 5'h08, 5'h06, 5'h07, 5'h04, 5'h05, 5'h01, 5'h0D,
                  5'h02, 5'h03, 5'h09, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14,
                  5'h15, 5'h16, 5'h17};
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 3) == 0) f = 5'($urandom_range(0, 31));
            else f = codes[$urandom_range(0, 18)];
            if (f[4]) f[3] = 1'($urandom_range(0, 1));
            av = pick(cur_w);
            bv = pick(cur_w);
            run_model($sformatf("rnd%0d_w%0d_f%h", i, cur_w, f), f, av, bv);
        end
    endtask

    initial begin
        int cnt;
        int rvs;
        rst       = 1'b1;
        a         = '0;
        b         = '0;
        fun       = '0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        check("rst_flags", {62'b0, opr, rv}, 64'b10);
        check("rst_result", res, 64'd0);
        rst = 1'b0;
        tick();

        run_exp("add_wrap", 5'h00, 32'hFFFFFFFF, 32'd1, 1, 64'h0);
        run_exp("sra", 5'h0D, 32'h80000000, 32'h24, 1, 64'hF8000000);
        run_exp("mul", 5'h10, 32'hFFFFFFF9, 32'd3, 33, 64'hFFFFFFEB);
        run_exp("mulh", 5'h11, 32'hFFFFFFF9, 32'd3, 33, 64'hFFFFFFFF);
        run_exp("mulhu", 5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
                64'hFFFFFFFE);
        run_exp("div", 5'h14, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFD);
        run_exp("rem", 5'h16, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF);
        run_exp("divu0", 5'h15, 32'd5, 32'd0, 1, 64'hFFFFFFFF);
        run_exp("remu0", 5'h17, 32'd5, 32'd0, 1, 64'd5);
        run_exp("div_ovf", 5'h14, 32'h80000000, 32'hFFFFFFFF, 1,
                64'h80000000);

        // Backpressure with an ignored request in the middle
        start_op(5'h10, 32'hFFFFFFF9, 32'd3);
        wait_result("bp", 33, 64'hFFFFFFEB);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                fun      = 5'h00;
                a        = 32'd1;
                b        = 32'd1;
                op_valid = 1'b1;
            end
            tick();
            op_valid = 1'b0;
            if (rv && !opr && res == 64'hFFFFFFEB) cnt++;
        end
        check("bp_hold", 64'(cnt), 64'd10);
        pop("bp");
        tick();
        tick();
        check("bp_no_queue", {63'b0, rv}, 64'd0);

        // Back-to-back base ops with RES_READY held high
        res_ready = 1'b1;
        op_valid  = 1'b1;
        fun       = 5'h00;
        a         = 32'd3;
        b         = 32'd4;
        rvs       = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rv && res == 64'd7) rvs++;
        end
        op_valid  = 1'b0;
        res_ready = 1'b0;
        check("b2b_count", 64'(rvs), 64'd5);
        tick();

        // Reset in the middle of a divide
        start_op(5'h14, 32'd100, 32'd7);
        for (int i = 0; i < 14; i++) tick();
        check("mid_busy", {62'b0, opr, rv}, 64'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_flags", {62'b0, opr, rv}, 64'b10);
        check("mid_rst_res", res, 64'd0);
        tick();
        tick();
        check("mid_rst_quiet", {63'b0, rv}, 64'd0);

        // Reset wins over a simultaneous request
        rst      = 1'b1;
        op_valid = 1'b1;
        fun      = 5'h00;
        a        = 32'd1;
        b        = 32'd1;
        tick();
        rst      = 1'b0;
        op_valid = 1'b0;
        check("rst_prio", {62'b0, opr, rv}, 64'b10);
        run_exp("mul_after_rst", 5'h10, 32'd6, 32'd7, 33, 64'd42);

        random_ops(30);

        cur_w = 8;
        tick();
        run_exp("w8_mul", 5'h10, 32'hF9, 32'd3, 9, 64'hEB);
        run_exp("w8_slt", 5'h02, 32'h80, 32'h01, 1, 64'd1);
        run_exp("w8_div_ovf", 5'h14, 32'h80, 32'hFF, 1, 64'h80);
        random_ops(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have derived localparam SHW = log2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port ALU_A, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port ALU_B, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port ALU_FUN, input, 5 bits: operation select, where bit4=0 selects a base op and bit4=1 selects an M-extension op.
REQ-008 The block SHALL have port OP_VALID, input, 1 bit: the requester presents a valid operation.
REQ-009 The block SHALL have port OP_READY, output, 1 bit: the block can accept an operation.
REQ-010 The block SHALL have port RES_VALID, output, 1 bit: ALU_RESULT holds a completed result.
REQ-011 The block SHALL have port RES_READY, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port ALU_RESULT, output, WIDTH bits: the registered result.

Function
REQ-013 The block SHALL accept an operation on a rising edge where OP_VALID and OP_READY are both 1, capturing ALU_A, ALU_B and ALU_FUN on that edge.
REQ-014 The block SHALL use FSM states IDLE, MUL, DIV and DONE, and SHALL drive OP_READY = 1 only in IDLE.
REQ-015 The block SHALL decode base ops (bit4=0) as follows:
- 0000 add
- 1000 sub
- 0110 or
- 0111 and
- 0100 xor
- 0101 srl
- 0001 sll
- 1101 sra
- 0010 slt (signed compare, result 0/1 zero-extended)
- 0011 sltu
- 1001 copy A
- all other codes give 0
REQ-016 Shift ops SHALL use only ALU_B[SHW-1:0]; add/sub SHALL wrap modulo 2^WIDTH.
REQ-017 A base op SHALL go IDLE->DONE, with the result registered on the accept edge, so RES_VALID = 1 in the cycle after acceptance.
REQ-018 M ops (bit4=1) SHALL use ALU_FUN[2:0] as follows:
- 000 MUL: low WIDTH bits
- 001 MULH: signed x signed, high bits
- 010 MULHSU: signed A x unsigned B, high bits
- 011 MULHU: high bits
- 100 DIV: signed, truncates toward zero
- 101 DIVU
- 110 REM: sign follows the dividend
- 111 REMU
- ALU_FUN[3] is ignored
REQ-019 Multiply SHALL be iterative shift-add on operand magnitudes with sign fix-up at the end, entering MUL for exactly WIDTH cycles and then going to DONE, so RES_VALID rises WIDTH+1 cycles after the accept edge.
REQ-020 Divide SHALL be iterative restoring division, one quotient bit per cycle, in DIV for exactly WIDTH cycles and then DONE, with the same latency as multiply.
REQ-021 Divide by zero SHALL skip DIV and go directly to DONE (1-cycle latency), giving quotient all-ones and remainder equal to ALU_A.
REQ-022 Signed overflow (ALU_A = most-negative, ALU_B = all-ones, DIV/REM) SHALL go directly to DONE, giving quotient = ALU_A and remainder = 0.
REQ-023 In DONE, RES_VALID SHALL be 1 and ALU_RESULT SHALL be held stable until a rising edge with RES_READY = 1, after which the state SHALL be IDLE and RES_VALID = 0.
REQ-024 OP_VALID asserted outside IDLE SHALL be ignored, with no queuing; operand input changes after acceptance SHALL NOT affect the result.
REQ-025 RES_READY held at 1 constantly SHALL give one result per (latency+1) cycles; back-to-back acceptance SHALL resume in the IDLE cycle following DONE.
REQ-026 ALU_RESULT SHALL be 0 whenever the state is IDLE, MUL or DIV.

Reset
REQ-027 RST = 1 on a rising edge SHALL force state IDLE, OP_READY = 1, RES_VALID = 0, ALU_RESULT = 0, and clear the iteration counter and partial product/remainder registers, including mid-MUL/DIV, where the in-flight op is discarded.
REQ-028 If RST and OP_VALID are both 1 on the same edge, reset SHALL take priority and the operation SHALL NOT be accepted.

Verification
REQ-029 WIDTH=32: add with A=0xFFFFFFFF, B=1 -> RES_VALID one cycle after accept, ALU_RESULT=0x00000000; sra with A=0x80000000, B=0x24 -> 0xF8000000.
REQ-030 MUL with A=0xFFFFFFF9 (-7), B=3 -> RES_VALID exactly 33 cycles after accept, result 0xFFFFFFEB; MULH with the same operands -> 0xFFFFFFFF; MULHU with A=B=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV with A=-7, B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU with A=5, B=0 -> 0xFFFFFFFF after 1 cycle; REMU with A=5, B=0 -> 5; DIV with A=0x80000000, B=0xFFFFFFFF -> 0x80000000 after 1 cycle.
REQ-032 Backpressure: hold RES_READY = 0 for 10 cycles after RES_VALID -> ALU_RESULT stable, OP_READY = 0, and an OP_VALID pulse is ignored; then RES_READY = 1 -> IDLE on the next edge.
REQ-033 Assert RST at cycle 15 of a DIV -> next cycle IDLE, RES_VALID = 0, ALU_RESULT = 0; a new MUL with A=6, B=7 -> 42 with full 33-cycle latency.
REQ-034 Rerun the scenarios at WIDTH=8: MUL with A=0xF9, B=3 -> 0xEB after 9 cycles; slt with A=0x80, B=0x01 -> 1.
